mux2a1_ochobits_cond: RTL and testbench

- Lane-combining counterpart to the 1-to-2 byte demux: merges two 8-bit lanes, each with its own valid, into one byte stream at twice the lane rate.
- Runs on clk_2f only. An internal phase bit stands in for the clk_f boundary: lanes are sampled as a pair every second clk_2f edge and emitted lane 0 first, then lane 1.
- A byte whose valid is low is discarded: it produces an idle output slot and does not update the data.

---
 rtl/mux2a1_ochobits_cond_if.sv | 30 +++
 rtl/mux2a1_ochobits_cond.sv | 54 +++++
 tb/tb_mux2a1_ochobits_cond.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux2a1_ochobits_cond_if.sv
// Lane-pair input and merged byte-stream output bundle for mux2a1_ochobits_cond.
// The master side drives the two lanes; the slave side (the combiner) drives the stream.
interface mux2a1_ochobits_cond_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid0;
  logic             valid1;
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;

  modport master (
    output valid0,
    output valid1,
    output data_in0,
    output data_in1,
    input  valid_out,
    input  data_out
  );

  modport slave (
    input  valid0,
    input  valid1,
    input  data_in0,
    input  data_in1,
    output valid_out,
    output data_out
  );
endinterface

// File: rtl/mux2a1_ochobits_cond.sv
// Merges two byte lanes into one stream at twice the lane rate, lane 0 first.
// Bytes with valid low leave an idle slot and do not disturb data_out.
module mux2a1_ochobits_cond #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk_2f,
  input  logic                    reset_L,
  mux2a1_ochobits_cond_if.slave   bus
);

  logic             phase_q, phase_d;
  logic [WIDTH-1:0] hold1_q, hold1_d;
  logic             hold_v1_q, hold_v1_d;
  logic             valid_out_q, valid_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  // phase_q == 0 marks a pair edge: both lanes are sampled together, lane 1 is parked in hold1.
  always_comb begin
    phase_d     = ~phase_q;
    hold1_d     = hold1_q;
    hold_v1_d   = hold_v1_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    if (!phase_q) begin
      hold1_d     = bus.data_in1;
      hold_v1_d   = bus.valid1;
      valid_out_d = bus.valid0;
      if (bus.valid0) data_out_d = bus.data_in0;
    end else begin
      valid_out_d = hold_v1_q;
      if (hold_v1_q) data_out_d = hold1_q;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      phase_q     <= 1'b0;
      hold1_q     <= '0;
      hold_v1_q   <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      hold1_q     <= hold1_d;
      hold_v1_q   <= hold_v1_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_mux2a1_ochobits_cond.sv
// Bench for mux2a1_ochobits_cond: directed scenarios plus random lane pairs,
// checked against a slot-queue model of the merged stream.
module tb_mux2a1_ochobits_cond;

  logic clk_2f  = 1'b0;
  logic reset_L = 1'b1;

  mux2a1_ochobits_cond_if #(.WIDTH(8)) bus ();

  mux2a1_ochobits_cond #(.WIDTH(8)) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int errors = 0;

  // Model: each pair edge queues two output slots {valid, byte}; every edge emits one slot.
  logic [8:0] slots[$];
  logic       m_phase = 1'b0;
  logic       exp_v   = 1'b0;
  logic [7:0] exp_d   = 8'h00;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    slots.delete();
    m_phase = 1'b0;
    exp_v   = 1'b0;
    exp_d   = 8'h00;
  endtask

  // One clk_2f cycle: advance the model at the rising edge, compare on the falling edge.
  task automatic tick(input string tag);
    logic [8:0] s;
    @(posedge clk_2f);
    if (reset_L) begin
      if (!m_phase) begin
        slots.push_back({bus.valid0, bus.data_in0});
        slots.push_back({bus.valid1, bus.data_in1});
      end
      s = slots.pop_front();
      exp_v = s[8];
      if (s[8]) exp_d = s[7:0];
      m_phase = ~m_phase;
    end
    @(negedge clk_2f);
    chk(tag, {bus.valid_out, bus.data_out}, {exp_v, exp_d});
  endtask

  task automatic set_pair(input logic [7:0] d0, input logic v0, input logic [7:0] d1,
                          input logic v1);
    bus.data_in0 = d0;
    bus.valid0   = v0;
    bus.data_in1 = d1;
    bus.valid1   = v1;
  endtask

  initial begin
    set_pair(8'hFF, 1'b1, 8'hFF, 1'b1);

    // Reset with busy inputs: outputs stay cleared.
    #1 reset_L = 1'b0;
    #1 chk("reset_async_start", {bus.valid_out, bus.data_out}, 9'h000);
    model_reset();
    for (int i = 0; i < 4; i++) tick("reset_hold");
    reset_L = 1'b1;

    // Basic interleave, both lanes valid.
    for (int i = 1; i <= 3; i++) begin
      set_pair(8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1);
      tick("interleave_lane0");
      chk("interleave_a", {bus.valid_out, bus.data_out}, {1'b1, 8'hA0 + 8'(i)});
      tick("interleave_lane1");
      chk("interleave_b", {bus.valid_out, bus.data_out}, {1'b1, 8'hB0 + 8'(i)});
    end

    // Partial valid.
    set_pair(8'h11, 1'b1, 8'h22, 1'b0);
    tick("partial_a0");
    chk("partial_11_v", {bus.valid_out, bus.data_out}, 9'h111);
    tick("partial_a1");
    chk("partial_11_idle", {bus.valid_out, bus.data_out}, 9'h011);
    set_pair(8'h33, 1'b0, 8'h44, 1'b1);
    tick("partial_b0");
    chk("partial_33_dropped", {bus.valid_out, bus.data_out}, 9'h011);
    tick("partial_b1");
    chk("partial_44_v", {bus.valid_out, bus.data_out}, 9'h144);

    // Capture timing: lane 1 is latched at the pair edge; odd-edge lane 0 glitch ignored.
    set_pair(8'h50, 1'b1, 8'h55, 1'b1);
    tick("capture_lane0");
    bus.data_in1 = 8'h66;
    bus.data_in0 = 8'h77;
    bus.valid0   = 1'b1;
    tick("capture_lane1");
    chk("capture_holds_55", {bus.valid_out, bus.data_out}, 9'h155);
    set_pair(8'h01, 1'b0, 8'h02, 1'b0);
    tick("capture_no77_a");
    tick("capture_no77_b");
    chk("capture_no77", {bus.valid_out, bus.data_out}, 9'h055);

    // Reset between lane 0 and lane 1: pending lane 1 is dropped.
    set_pair(8'hC0, 1'b1, 8'hC1, 1'b1);
    tick("midreset_c0");
    reset_L = 1'b0;
    #1 chk("midreset_async_clear", {bus.valid_out, bus.data_out}, 9'h000);
    model_reset();
    for (int i = 0; i < 3; i++) tick("midreset_hold");
    reset_L = 1'b1;
    set_pair(8'hD0, 1'b1, 8'hD1, 1'b1);
    tick("resume_d0");
    chk("resume_d0_const", {bus.valid_out, bus.data_out}, 9'h1D0);
    tick("resume_d1");
    chk("resume_d1_const", {bus.valid_out, bus.data_out}, 9'h1D1);

    // Idle stream after 0x9E.
    set_pair(8'h9E, 1'b1, 8'h00, 1'b0);
    tick("idle_9e");
    tick("idle_9e_slot1");
    for (int i = 0; i < 4; i++) begin
      set_pair(8'($urandom), 1'b0, 8'($urandom), 1'b0);
      tick("idle_slot0");
      chk("idle_const0", {bus.valid_out, bus.data_out}, 9'h09E);
      tick("idle_slot1");
      chk("idle_const1", {bus.valid_out, bus.data_out}, 9'h09E);
    end

    // Random pairs with random glitches on odd edges.
    for (int i = 0; i < 60; i++) begin
      set_pair(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      tick("rand_lane0");
      set_pair(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      tick("rand_lane1");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
